tx_burst_controller: RTL and testbench
======================================

TX_BURST_CONTROLLER -- requirements
Module: tx_burst_controller

Interface
REQ-001 Parameter BURST_CYCLES, default 8, number of full transmit periods per burst (1..255).
REQ-002 Parameter DEAD_CLKS, default 16, ring-down clocks between burst end and listen window (1..255).
REQ-003 Parameter PRF_DIV, default 6400, mainclk cycles per internal pulse-repetition period (2..65535).
REQ-004 mainclk  in  1  system clock; every register is clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 TransmitterOn  in  1  enables bursts from the state handler; 0 = no new burst starts.
REQ-007 TriggerOn  in  1  start source: 1 = external trig_in rising edge; 0 = internal PRF counter.
REQ-008 Retransmit  in  1  abort/hold: 1 forces IDLE and all drive outputs low.
REQ-009 Frequency  in  2  half-period select: 00=16, 01=8, 10=4, 11=32 mainclk cycles (HALF).
REQ-010 trig_in  in  1  asynchronous external trigger.
REQ-011 TxP  out  1  positive transducer drive.
REQ-012 TxN  out  1  negative transducer drive.
REQ-013 TxActive  out  1  high for the whole BURST state.
REQ-014 RxGate  out  1  receive window, high in LISTEN state.
REQ-015 BurstStart  out  1  one-cycle pulse on the first BURST cycle.
REQ-016 TrigMissed  out  1  one-cycle pulse when a start event is discarded.

Function
REQ-017 trig_in SHALL pass a 2-flop synchronizer followed by rising-edge detect; an edge therefore becomes a start event 3 mainclk cycles after it is sampled.
REQ-018 PRF counter SHALL be 16 bits, free-running from reset, counting 0..PRF_DIV-1 and wrapping to 0; terminal count is an internal start event when TriggerOn=0.
REQ-019 Start events SHALL be qualified by TransmitterOn=1 and Retransmit=0; unqualified events are dropped silently.
REQ-020 States SHALL be IDLE, BURST, DEAD, LISTEN.
REQ-021 IDLE -> BURST on a qualified start event; LISTEN -> BURST on a qualified start event; the transition takes effect the next cycle.
REQ-022 On entering BURST, Frequency SHALL be latched; changes to Frequency during BURST SHALL have no effect until the next burst.
REQ-023 BURST SHALL last exactly BURST_CYCLES*2*HALF cycles; within each period, half 1 drives TxP and half 2 drives TxN.
REQ-024 The first cycle of every half-period SHALL be dead time with TxP=TxN=0; the remaining HALF-1 cycles drive the active line.
REQ-025 TxP and TxN SHALL never be 1 in the same cycle under any input sequence.
REQ-026 BURST -> DEAD after the final BURST cycle; DEAD lasts DEAD_CLKS cycles with all drive outputs 0; DEAD -> LISTEN.
REQ-027 LISTEN SHALL hold RxGate=1 until the next qualified start event; RxGate SHALL be 0 in every other state.
REQ-028 A qualified start event arriving in BURST or DEAD SHALL be discarded, raise TrigMissed for one cycle, and leave the state unaffected.
REQ-029 Retransmit=1 in any state SHALL force IDLE on the next cycle and clear TxP, TxN, TxActive and RxGate in that same next cycle; an in-progress burst is not resumed.
REQ-030 TransmitterOn falling during BURST SHALL NOT truncate the burst; it only blocks future starts.
REQ-031 If a start event and Retransmit=1 occur in the same cycle, Retransmit SHALL win: IDLE is entered and TrigMissed stays 0.
REQ-032 All outputs SHALL be registered; no combinational path SHALL run from any input to any output.

Reset
REQ-033 While reset=1, state SHALL be IDLE, the PRF counter and burst/half counters SHALL be 0, and synchronizer flops SHALL be 0.
REQ-034 While reset=1, TxP, TxN, TxActive, RxGate, BurstStart and TrigMissed SHALL all be 0.
REQ-035 Reset SHALL release synchronously to mainclk by an external reset synchronizer; the first edge-detect after release SHALL NOT fire on a trig_in held high through reset.

Verification
REQ-036 TriggerOn=0, TransmitterOn=1, Frequency=01, PRF_DIV=6400 -> BurstStart every 6400 cycles; 8 TxP pulses of 7 cycles and 8 TxN pulses of 7 cycles; TxActive high for 128 cycles.
REQ-037 TriggerOn=1 with a trig_in rising edge -> BurstStart 4 cycles after the sampling edge; DEAD lasts 16 cycles, then RxGate=1 until the next trigger.
REQ-038 Second trig_in edge 20 cycles into a burst -> TrigMissed pulses once; the burst completes unchanged.
REQ-039 Frequency changed from 11 to 10 mid-burst -> the current burst keeps HALF=32; the next burst uses HALF=4.
REQ-040 Retransmit raised mid-burst -> the next cycle shows TxP=TxN=TxActive=0 in IDLE; no bursts occur while it stays high.
REQ-041 Random inputs for 1e6 cycles with reset asserted mid-burst -> TxP&TxN never both 1; all outputs are 0 while reset=1.

Source files
------------

// File: rtl/tx_burst_controller.sv
// tx_burst_controller
//   Generates ultrasonic transmit bursts on a complementary TxP/TxN pair.
//   After each burst come a ring-down (DEAD) interval and a receive window (LISTEN).
//   Bursts start on an external trigger edge or on the internal PRF counter.
//
// Ports
//   mainclk       in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   TransmitterOn in   1 = start events may launch a burst
//   TriggerOn     in   1 = trig_in rising edge starts a burst, 0 = PRF counter
//   Retransmit    in   1 = abort to IDLE and hold all drives low
//   Frequency     in   half-period select: 00=16, 01=8, 10=4, 11=32 clocks
//   trig_in       in   asynchronous external trigger
//   TxP, TxN      out  positive / negative transducer drive
//   TxActive      out  high throughout BURST
//   RxGate        out  high throughout LISTEN
//   BurstStart    out  one-cycle pulse on the first BURST cycle
//   TrigMissed    out  one-cycle pulse when a start event arrives in BURST/DEAD
module tx_burst_controller #(
  parameter int unsigned BURST_CYCLES = 8,
  parameter int unsigned DEAD_CLKS    = 16,
  parameter int unsigned PRF_DIV      = 6400
) (
  input  logic       mainclk,
  input  logic       reset,
  input  logic       TransmitterOn,
  input  logic       TriggerOn,
  input  logic       Retransmit,
  input  logic [1:0] Frequency,
  input  logic       trig_in,
  output logic       TxP,
  output logic       TxN,
  output logic       TxActive,
  output logic       RxGate,
  output logic       BurstStart,
  output logic       TrigMissed
);

  typedef enum logic [1:0] {IDLE, BURST, DEAD, LISTEN} state_t;

  localparam logic [15:0] PRF_LAST   = 16'(PRF_DIV - 1);
  localparam logic [7:0]  BURST_LAST = 8'(BURST_CYCLES - 1);
  localparam logic [7:0]  DEAD_LAST  = 8'(DEAD_CLKS - 1);

  logic       trigSync1_q, trigSync2_q, trigLvl_q, trigPrev_q, trigEvt_q;
  logic [3:0] trigValid_q;
  logic [15:0] prfCnt_q;
  logic       prfTc;

  state_t     state_q, state_d;
  logic [5:0] halfCnt_q, halfCnt_d;
  logic [5:0] halfLen_q, halfLen_d;
  logic       phase_q, phase_d;
  logic [7:0] burstCnt_q, burstCnt_d;
  logic [7:0] deadCnt_q, deadCnt_d;
  logic       txP_q, txP_d, txN_q, txN_d, txActive_q, txActive_d;
  logic       rxGate_q, rxGate_d, burstStart_q, burstStart_d;
  logic       trigMissed_q, trigMissed_d;
  logic       startQual;
  logic [5:0] halfSel;

  // Two-flop synchronizer, then a registered rising-edge detector.
  // trigValid_q gates the detector until trigPrev_q holds a real post-reset
  // sample, so a trigger held high through reset is not seen as an edge.
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      trigSync1_q <= 1'b0;
      trigSync2_q <= 1'b0;
      trigLvl_q   <= 1'b0;
      trigPrev_q  <= 1'b0;
      trigValid_q <= 4'b0;
      trigEvt_q   <= 1'b0;
    end else begin
      trigSync1_q <= trig_in;
      trigSync2_q <= trigSync1_q;
      trigLvl_q   <= trigSync2_q;
      trigPrev_q  <= trigLvl_q;
      trigValid_q <= {trigValid_q[2:0], 1'b1};
      trigEvt_q   <= trigLvl_q & ~trigPrev_q & trigValid_q[3];
    end
  end

  // Free-running pulse-repetition counter; its terminal count is the
  // internal start event.
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      prfCnt_q <= '0;
    end else if (prfCnt_q == PRF_LAST) begin
      prfCnt_q <= '0;
    end else begin
      prfCnt_q <= prfCnt_q + 16'd1;
    end
  end

  assign prfTc = (prfCnt_q == PRF_LAST);

  // State, counters and registered outputs.
  always_ff @(posedge mainclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      halfCnt_q    <= '0;
      halfLen_q    <= '0;
      phase_q      <= 1'b0;
      burstCnt_q   <= '0;
      deadCnt_q    <= '0;
      txP_q        <= 1'b0;
      txN_q        <= 1'b0;
      txActive_q   <= 1'b0;
      rxGate_q     <= 1'b0;
      burstStart_q <= 1'b0;
      trigMissed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      halfCnt_q    <= halfCnt_d;
      halfLen_q    <= halfLen_d;
      phase_q      <= phase_d;
      burstCnt_q   <= burstCnt_d;
      deadCnt_q    <= deadCnt_d;
      txP_q        <= txP_d;
      txN_q        <= txN_d;
      txActive_q   <= txActive_d;
      rxGate_q     <= rxGate_d;
      burstStart_q <= burstStart_d;
      trigMissed_q <= trigMissed_d;
    end
  end

  // Next-state logic. Outputs are derived from the next state so they
  // line up with the state register while still coming straight from flops.
  // phase 0 is the TxP half, phase 1 the TxN half; halfCnt 0 is dead time.
  always_comb begin
    state_d      = state_q;
    halfCnt_d    = halfCnt_q;
    halfLen_d    = halfLen_q;
    phase_d      = phase_q;
    burstCnt_d   = burstCnt_q;
    deadCnt_d    = deadCnt_q;
    burstStart_d = 1'b0;
    trigMissed_d = 1'b0;
    startQual    = (TriggerOn ? trigEvt_q : prfTc) & TransmitterOn & ~Retransmit;

    case (Frequency)
      2'b00:   halfSel = 6'd16;
      2'b01:   halfSel = 6'd8;
      2'b10:   halfSel = 6'd4;
      default: halfSel = 6'd32;
    endcase

    if (Retransmit) begin
      state_d    = IDLE;
      halfCnt_d  = '0;
      phase_d    = 1'b0;
      burstCnt_d = '0;
      deadCnt_d  = '0;
    end else begin
      case (state_q)
        IDLE, LISTEN: begin
          if (startQual) begin
            state_d      = BURST;
            halfCnt_d    = '0;
            phase_d      = 1'b0;
            burstCnt_d   = '0;
            halfLen_d    = halfSel;
            burstStart_d = 1'b1;
          end
        end
        BURST: begin
          trigMissed_d = startQual;
          if (halfCnt_q == halfLen_q - 6'd1) begin
            halfCnt_d = '0;
            phase_d   = ~phase_q;
            if (phase_q) begin
              if (burstCnt_q == BURST_LAST) begin
                state_d    = DEAD;
                burstCnt_d = '0;
                deadCnt_d  = '0;
              end else begin
                burstCnt_d = burstCnt_q + 8'd1;
              end
            end
          end else begin
            halfCnt_d = halfCnt_q + 6'd1;
          end
        end
        DEAD: begin
          trigMissed_d = startQual;
          if (deadCnt_q == DEAD_LAST) begin
            state_d   = LISTEN;
            deadCnt_d = '0;
          end else begin
            deadCnt_d = deadCnt_q + 8'd1;
          end
        end
      endcase
    end

    txActive_d = (state_d == BURST);
    txP_d      = txActive_d && (halfCnt_d != 6'd0) && !phase_d;
    txN_d      = txActive_d && (halfCnt_d != 6'd0) && phase_d;
    rxGate_d   = (state_d == LISTEN);
  end

  assign TxP        = txP_q;
  assign TxN        = txN_q;
  assign TxActive   = txActive_q;
  assign RxGate     = rxGate_q;
  assign BurstStart = burstStart_q;
  assign TrigMissed = trigMissed_q;

endmodule

// File: tb/tb_tx_burst_controller.sv
// tb_tx_burst_controller
//   Self-checking bench for tx_burst_controller with default parameters.
//   Expected per-cycle output vectors {TxP,TxN,TxActive,RxGate,BurstStart,TrigMissed}
//   are queued as stimulus is driven and compared as the DUT produces them.
module tb_tx_burst_controller;

  localparam int NBURST = 8;
  localparam int NDEAD  = 16;
  localparam int NPRF   = 6400;

  logic       mainclk = 1'b0;
  logic       reset;
  logic       TransmitterOn, TriggerOn, Retransmit, trig_in;
  logic [1:0] Frequency;
  logic       TxP, TxN, TxActive, RxGate, BurstStart, TrigMissed;

  int total = 0;
  int bad   = 0;

  logic [5:0] expQ[$];

  typedef struct {
    logic [1:0] freqCode;
    int         expHalf;
    logic [1:0] midCode;
  } vec_t;

  vec_t vecs[4];

  tx_burst_controller #(
    .BURST_CYCLES(NBURST),
    .DEAD_CLKS(NDEAD),
    .PRF_DIV(NPRF)
  ) dut (
    .mainclk(mainclk),
    .reset(reset),
    .TransmitterOn(TransmitterOn),
    .TriggerOn(TriggerOn),
    .Retransmit(Retransmit),
    .Frequency(Frequency),
    .trig_in(trig_in),
    .TxP(TxP),
    .TxN(TxN),
    .TxActive(TxActive),
    .RxGate(RxGate),
    .BurstStart(BurstStart),
    .TrigMissed(TrigMissed)
  );

  // 10-unit clock period
  always #5 mainclk = ~mainclk;

  // Bounds the whole run in case the DUT stalls the bench
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [5:0] outVec();
    return {TxP, TxN, TxActive, RxGate, BurstStart, TrigMissed};
  endfunction

  task automatic applyStimulus(input logic txOn, input logic trigOn, input logic retx,
                               input logic [1:0] freq, input logic trig);
    TransmitterOn = txOn;
    TriggerOn     = trigOn;
    Retransmit    = retx;
    Frequency     = freq;
    trig_in       = trig;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b (TxP,TxN,Act,Rx,BS,TM) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic stepCompare(input string name);
    logic [5:0] exp;
    @(negedge mainclk);
    exp = expQ.pop_front();
    checkOutput(name, outVec(), exp);
  endtask

  task automatic pushIdle(input int n, input logic rx);
    for (int k = 0; k < n; k++) expQ.push_back({3'b000, rx, 2'b00});
  endtask

  // One full burst: NBURST periods, each a TxP half then a TxN half,
  // first cycle of every half is dead time.
  task automatic pushBurst(input int half);
    for (int p = 0; p < NBURST; p++)
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < half; c++)
          expQ.push_back({(h == 0) && (c != 0), (h == 1) && (c != 0), 1'b1, 1'b0,
                          (p == 0) && (h == 0) && (c == 0), 1'b0});
  endtask

  initial begin
    logic       inListen;
    logic       found;
    logic       prevRetx;
    logic [5:0] tmp;

    vecs[0] = '{freqCode: 2'b01, expHalf: 8,  midCode: 2'b00};
    vecs[1] = '{freqCode: 2'b00, expHalf: 16, midCode: 2'b11};
    vecs[2] = '{freqCode: 2'b11, expHalf: 32, midCode: 2'b10};
    vecs[3] = '{freqCode: 2'b10, expHalf: 4,  midCode: 2'b01};

    // Reset with trig_in held high throughout
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    repeat (3) begin
      @(negedge mainclk);
      checkOutput("resetOutputs", outVec(), 6'b0);
    end
    reset = 1'b0;
    repeat (10) begin
      @(negedge mainclk);
      checkOutput("heldTrigNoStart", outVec(), 6'b0);
    end
    trig_in = 1'b0;
    repeat (4) begin
      @(negedge mainclk);
      checkOutput("idleAfterRelease", outVec(), 6'b0);
    end

    // Table: one triggered burst per Frequency code; Frequency is changed
    // mid-burst to the next entry's code, which must not affect this burst.
    inListen = 1'b0;
    foreach (vecs[v]) begin
      applyStimulus(1'b1, 1'b1, 1'b0, vecs[v].freqCode, 1'b1);
      pushIdle(4, inListen);
      pushBurst(vecs[v].expHalf);
      pushIdle(NDEAD, 1'b0);
      pushIdle(6, 1'b1);
      for (int i = 0; expQ.size() > 0; i++) begin
        stepCompare("freqTable");
        if (i == 1)  trig_in = 1'b0;
        if (i == 20) Frequency = vecs[v].midCode;
      end
      inListen = 1'b1;
    end

    // Second edge mid-burst: TrigMissed once, burst unchanged; TransmitterOn
    // dropped mid-burst does not truncate it and blocks the start in LISTEN.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    pushIdle(4, 1'b1);
    pushBurst(8);
    tmp = expQ[25];
    tmp[0] = 1'b1;
    expQ[25] = tmp;
    pushIdle(NDEAD, 1'b0);
    pushIdle(20, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      stepCompare("missedTrig");
      if (i == 1)   trig_in = 1'b0;
      if (i == 20)  trig_in = 1'b1;
      if (i == 22)  trig_in = 1'b0;
      if (i == 40)  TransmitterOn = 1'b0;
      if (i == 150) trig_in = 1'b1;
      if (i == 160) trig_in = 1'b0;
    end
    TransmitterOn = 1'b1;

    // Retransmit mid-burst, arriving on the same edge as a second start event
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    pushIdle(4, 1'b1);
    pushBurst(8);
    while (expQ.size() > 30) void'(expQ.pop_back());
    pushIdle(40, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      stepCompare("retransmit");
      if (i == 1)  trig_in = 1'b0;
      if (i == 25) trig_in = 1'b1;
      if (i == 29) Retransmit = 1'b1;
      if (i == 35) trig_in = 1'b0;
      if (i == 45) trig_in = 1'b1;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0);

    // Internal PRF source: burst every NPRF cycles
    TriggerOn = 1'b0;
    found = 1'b0;
    for (int c = 0; c < NPRF + 600; c++) begin
      @(negedge mainclk);
      if (BurstStart === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("prfFirstStart", {5'b0, found}, 6'b000001);
    if (found) begin
      pushBurst(8);
      void'(expQ.pop_front());
      pushIdle(NDEAD, 1'b0);
      pushIdle(NPRF - 2 * 8 * NBURST - NDEAD, 1'b1);
      pushBurst(8);
      while (expQ.size() > 0) stepCompare("prfPeriod");
    end

    // Random inputs: drives never overlap, Retransmit always clears outputs
    prevRetx = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge mainclk);
      checkOutput("noOverlap", {5'b0, TxP & TxN}, 6'b0);
      if (prevRetx) checkOutput("retxClears", outVec(), 6'b0);
      if (c % 500 == 0) TriggerOn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) trig_in = ~trig_in;
      Retransmit    = ($urandom_range(0, 199) == 0);
      TransmitterOn = ($urandom_range(0, 19) != 0);
      Frequency     = 2'($urandom_range(0, 3));
      prevRetx      = Retransmit;
    end

    // Reset asserted in the middle of a burst
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    repeat (2) @(negedge mainclk);
    Retransmit = 1'b0;
    repeat (3) @(negedge mainclk);
    trig_in = 1'b1;
    repeat (30) @(negedge mainclk);
    checkOutput("burstBeforeReset", {5'b0, TxActive}, 6'b000001);
    reset = 1'b1;
    #1;
    checkOutput("asyncResetClears", outVec(), 6'b0);
    repeat (4) begin
      @(negedge mainclk);
      checkOutput("resetHold", outVec(), 6'b0);
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge mainclk);
      checkOutput("heldTrigAfterReset", outVec(), 6'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
